// File: rtl/cache_maint_pkg.sv
// Shared types for the cache maintenance sequencer.
//   maint_state_t : sequencer FSM states
//   maint_op_t    : latched maintenance operation
package cache_maint_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDReq,
        StDDrop,
        StIReq,
        StIDrop,
        StAck
    } maint_state_t;

    typedef enum logic [1:0] {
        OpFenceI,
        OpDflush,
        OpIclear
    } maint_op_t;

endpackage

// File: rtl/maint_timeout_cnt.sv
// Saturating cycle counter used to bound how long a cache request may stay
// outstanding.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count to zero (has priority over enable)
//   enable   : count this cycle
//   expired  : this cycle's increment reaches LIMIT (never set when LIMIT == 0)
module maint_timeout_cnt #(
    parameter int unsigned LIMIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(LIMIT);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     cnt_ext;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Compare in 32 bits so cnt_q + 1 cannot wrap at the top of the range.
    assign cnt_ext = 32'(cnt_q);
    assign expired = (LIMIT != 0) && enable && !clear && ((cnt_ext + 32'd1) >= LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_maint_ctrl.sv
// Sequences cache maintenance requests (fence.i, D-cache flush, I-cache clear)
// onto the caches' clear/flush handshake and returns a one-cycle ack.
//   CLK, RST           : clock, synchronous active-high reset
//   fence_i_req        : D-cache flush then I-cache clear (level, held until ack)
//   dflush_req         : D-cache flush only (level, held until ack)
//   iclear_req         : I-cache clear only (level, held until ack)
//   dcache_flush       : request to D-cache, dcache_flush_done its completion
//   icache_clear       : request to I-cache, icache_clear_done its completion
//   busy               : high whenever not idle
//   ack                : one-cycle pulse on completion or abort
//   timeout_err        : sticky abort flag, cleared when a new request is accepted
module cache_maint_ctrl
    import cache_maint_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic CLK,
    input  logic RST,
    input  logic fence_i_req,
    input  logic dflush_req,
    input  logic iclear_req,
    output logic dcache_flush,
    input  logic dcache_flush_done,
    output logic icache_clear,
    input  logic icache_clear_done,
    output logic busy,
    output logic ack,
    output logic timeout_err
);

    maint_state_t state_q, state_d;
    maint_op_t    op_q, op_d;
    logic         terr_d;
    logic         in_req;
    logic         expired;

    assign in_req = (state_q == StDReq) || (state_q == StIReq);

    // Held at zero outside the request states, so it starts from zero on entry.
    maint_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (CLK),
        .rst     (RST),
        .clear   (!in_req),
        .enable  (in_req),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        terr_d  = timeout_err;
        case (state_q)
            StIdle: begin
                if (fence_i_req) begin
                    op_d    = OpFenceI;
                    state_d = StDReq;
                    terr_d  = 1'b0;
                end else if (dflush_req) begin
                    op_d    = OpDflush;
                    state_d = StDReq;
                    terr_d  = 1'b0;
                end else if (iclear_req) begin
                    op_d    = OpIclear;
                    state_d = StIReq;
                    terr_d  = 1'b0;
                end
            end
            StDReq: begin
                // A done arriving on the expiry cycle still counts as completion.
                if (dcache_flush_done) begin
                    state_d = StDDrop;
                end else if (expired) begin
                    state_d = StAck;
                    terr_d  = 1'b1;
                end
            end
            StDDrop: begin
                if (!dcache_flush_done) begin
                    state_d = (op_q == OpFenceI) ? StIReq : StAck;
                end
            end
            StIReq: begin
                if (icache_clear_done) begin
                    state_d = StIDrop;
                end else if (expired) begin
                    state_d = StAck;
                    terr_d  = 1'b1;
                end
            end
            StIDrop: begin
                if (!icache_clear_done) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            op_q         <= OpDflush;
            dcache_flush <= 1'b0;
            icache_clear <= 1'b0;
            busy         <= 1'b0;
            ack          <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            dcache_flush <= (state_d == StDReq);
            icache_clear <= (state_d == StIReq);
            busy         <= (state_d != StIdle);
            ack          <= (state_d == StAck);
            timeout_err  <= terr_d;
        end
    end

endmodule

// File: tb/tb_cache_maint_ctrl.sv
// Directed bench for cache_maint_ctrl. Stimulus pushes each expected ack
// (cycle and timeout_err value) into a queue; a monitor pops one per ack.
module tb_cache_maint_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic fence_i_req, dflush_req, iclear_req;
    logic dcache_flush, dcache_flush_done;
    logic icache_clear, icache_clear_done;
    logic busy, ack, timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int   cyc;
        logic terr;
    } exp_ack_t;

    exp_ack_t exp_q[$];

    cache_maint_ctrl #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .fence_i_req       (fence_i_req),
        .dflush_req        (dflush_req),
        .iclear_req        (iclear_req),
        .dcache_flush      (dcache_flush),
        .dcache_flush_done (dcache_flush_done),
        .icache_clear      (icache_clear),
        .icache_clear_done (icache_clear_done),
        .busy              (busy),
        .ack               (ack),
        .timeout_err       (timeout_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ack must match the next expected entry.
    always @(negedge CLK) begin
        exp_ack_t e;
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: actual ack 1 required 0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        RST               = 1'b1;
        fence_i_req       = 1'b0;
        dflush_req        = 1'b1;
        iclear_req        = 1'b0;
        dcache_flush_done = 1'b0;
        icache_clear_done = 1'b0;

        // Reset for two cycles with a request held: nothing may be issued.
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk("rst_busy", busy, 0);
            chk("rst_dflush", dcache_flush, 0);
            chk("rst_iclear", icache_clear, 0);
            chk("rst_ack", ack, 0);
            chk("rst_terr", timeout_err, 0);
        end
        dflush_req = 1'b0;
        RST        = 1'b0;
        @(negedge CLK);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_dflush", dcache_flush, 0);

        // DFLUSH: done one cycle at k=3, ack at k=5.
        @(negedge CLK);
        c0 = cyc;
        dflush_req = 1'b1;
        exp_q.push_back('{c0 + 5, 1'b0});
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            chk("dfl_flush", dcache_flush, (k <= 3));
            chk("dfl_iclear", icache_clear, 0);
            chk("dfl_busy", busy, (k <= 5));
            dcache_flush_done = (k == 3);
            if (k == 5) dflush_req = 1'b0;
        end

        // FENCE_I: D done held 3 cycles; I clear only after D done falls.
        @(negedge CLK);
        c0 = cyc;
        fence_i_req = 1'b1;
        exp_q.push_back('{c0 + 8, 1'b0});
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            chk("fence_flush", dcache_flush, (k <= 2));
            chk("fence_iclear", icache_clear, (k == 6));
            chk("fence_busy", busy, (k <= 8));
            dcache_flush_done = (k >= 2) && (k <= 4);
            icache_clear_done = (k == 6);
            if (k == 8) fence_i_req = 1'b0;
        end

        // Priority: fence.i and iclear together; fence.i first, iclear after.
        @(negedge CLK);
        c0 = cyc;
        fence_i_req = 1'b1;
        iclear_req  = 1'b1;
        exp_q.push_back('{c0 + 5, 1'b0});
        exp_q.push_back('{c0 + 9, 1'b0});
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            chk("prio_flush", dcache_flush, (k == 1));
            chk("prio_iclear", icache_clear, (k == 3) || (k == 7));
            chk("prio_busy", busy, (k != 6) && (k <= 9));
            dcache_flush_done = (k == 1);
            icache_clear_done = (k == 3) || (k == 7);
            if (k == 5) fence_i_req = 1'b0;
            if (k == 9) iclear_req = 1'b0;
        end

        // Timeout: fence.i, D-cache never done; abort after 8 request cycles.
        @(negedge CLK);
        c0 = cyc;
        fence_i_req = 1'b1;
        exp_q.push_back('{c0 + 9, 1'b1});
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            chk("to_flush", dcache_flush, (k <= 8));
            chk("to_iclear", icache_clear, 0);
            chk("to_terr", timeout_err, (k >= 9));
            if (k == 9) fence_i_req = 1'b0;
        end

        // Next request clears the sticky error on acceptance.
        @(negedge CLK);
        chk("terr_sticky", timeout_err, 1);
        c0 = cyc;
        dflush_req = 1'b1;
        exp_q.push_back('{c0 + 3, 1'b0});
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            chk("clr_terr", timeout_err, 0);
            chk("clr_flush", dcache_flush, (k == 1));
            dcache_flush_done = (k == 1);
            if (k == 3) dflush_req = 1'b0;
        end

        // Reset while in I_REQ: request and busy drop next edge, no ack.
        @(negedge CLK);
        iclear_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            if (k <= 2) begin
                chk("mid_iclear", icache_clear, 1);
                chk("mid_busy", busy, 1);
            end else begin
                chk("mid_rst_iclear", icache_clear, 0);
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_ack", ack, 0);
            end
            if (k == 2) RST = 1'b1;
            if (k == 3) begin
                RST        = 1'b0;
                iclear_req = 1'b0;
            end
        end

        repeat (3) @(negedge CLK);
        chk("acks_outstanding", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_maint_ctrl.md
# cache_maint_ctrl

Upstream sequencer driving the cache maintenance handshake (`clear`/`flush` with `clear_done`/`flush_done`) of the data and instruction caches. It accepts maintenance requests from the pipeline/CSR unit (fence.i, D-cache flush, I-cache clear), orders them, holds each cache request until that cache reports completion, and returns a single-cycle acknowledge. Sits between the execute/CSR stage and the caches' `cache` modport.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 0: cycles a cache request may stay outstanding before abort; 0 disables the timeout.

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `fence_i_req`  in  1  level; D-cache flush, then I-cache clear. Held until `ack`.
- `dflush_req`  in  1  level; D-cache flush only. Held until `ack`.
- `iclear_req`  in  1  level; I-cache clear only. Held until `ack`.
- `dcache_flush`  out  1  to D-cache `flush`.
- `dcache_flush_done`  in  1  from D-cache `flush_done`.
- `icache_clear`  out  1  to I-cache `clear`.
- `icache_clear_done`  in  1  from I-cache `clear_done`.
- `busy`  out  1  high in every state except IDLE; pipeline stall.
- `ack`  out  1  one-cycle pulse on completion or abort.
- `timeout_err`  out  1  sticky; set on abort, cleared when the next request is accepted.

## Operation
- States: IDLE, D_REQ, D_DROP, I_REQ, I_DROP, ACK.
- IDLE: priority `fence_i_req` > `dflush_req` > `iclear_req`. Accept one; latch op (FENCE_I / DFLUSH / ICLEAR); clear `timeout_err`. FENCE_I and DFLUSH -> D_REQ; ICLEAR -> I_REQ.
- D_REQ: `dcache_flush`=1. On `dcache_flush_done`=1 -> D_DROP.
- D_DROP: `dcache_flush`=0; wait for `dcache_flush_done`=0 (stale done never counted twice). Then FENCE_I -> I_REQ; DFLUSH -> ACK.
- I_REQ: `icache_clear`=1. On `icache_clear_done`=1 -> I_DROP.
- I_DROP: `icache_clear`=0; wait for `icache_clear_done`=0, then -> ACK.
- ACK: `ack`=1 for one cycle -> IDLE. Requests are ignored in ACK; the requester drops its level on the ack edge, so the next IDLE sample sees only new requests.
- Timeout (TIMEOUT_CYCLES>0): counter, width $clog2(TIMEOUT_CYCLES+1), zeroed on entry to D_REQ/I_REQ, increments each cycle there; on reaching TIMEOUT_CYCLES: drop the request, set `timeout_err`, -> ACK (remaining FENCE_I steps skipped). Saturates, never wraps. Not active in *_DROP states.
- Lower-priority simultaneous requests are not latched; they stay pending because their requester holds the level.
- Done asserted with no outstanding request is ignored.

## Timing
- All outputs registered. Reset value: every output 0, state IDLE, counter 0.
- Request sampled in IDLE at edge t -> `busy`, cache request high from t+1.
- Done sampled at edge t -> request low from t+1.
- Minimum DFLUSH latency (request to `ack`), done pulsed one cycle: 4 cycles (IDLE->D_REQ->D_DROP->ACK). FENCE_I minimum: 6.
- `RST` mid-operation: next edge all outputs 0, IDLE, no `ack`; caches must tolerate a request dropped before done.

## Structure
- Package `cache_maint_pkg`: state enum `maint_state_t`, op enum `maint_op_t` (FENCE_I, DFLUSH, ICLEAR).
- One sub-module: `maint_timeout_cnt` (parameterised saturating counter with clear/enable/expired).

## Test plan
- Reset: assert `RST` 2 cycles -> all outputs 0; pulse `dflush_req` during reset -> no request issued.
- DFLUSH: `dflush_req` at t0, `dcache_flush_done` one cycle at t3 -> `dcache_flush` high t1..t3, `ack` at t5, `icache_clear` never high.
- FENCE_I ordering: `fence_i_req` with D-cache done held 3 cycles -> `icache_clear` rises only after `dcache_flush_done` falls; single `ack` at end.
- Priority: `iclear_req` and `fence_i_req` same cycle -> FENCE_I served first; ICLEAR served after, 2 `ack` pulses total.
- Timeout: TIMEOUT_CYCLES=8, FENCE_I, D-cache never done -> `dcache_flush` drops after 8 cycles, `timeout_err`=1, `ack`, no `icache_clear`; next request clears `timeout_err`.
- Reset mid-op: `RST` while in I_REQ -> `icache_clear`/`busy` 0 next edge, no `ack`.
